// File: rtl/ttl_scan_sequencer_if.sv
// Scan control and decoder-drive bundle between a controller and ttl_scan_sequencer.
// The sequencer side uses the slave modport; the controller side uses master.
interface ttl_scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         first;
    logic [2:0]         last;
    logic               A;
    logic               B;
    logic               C;
    logic               G_n;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, cont, dwell, first, last,
        input  A, B, C, G_n, busy, done, wrap
    );

    modport slave (
        input  start, stop, cont, dwell, first, last,
        output A, B, C, G_n, busy, done, wrap
    );
endinterface

// File: rtl/ttl_scan_sequencer.sv
// Drives the select/strobe pins of a 74155 wired as a 3-to-8 decoder, scanning an address
// window with setup and hold guard intervals so the decoder never sees an address change under strobe.
module ttl_scan_sequencer #(
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ttl_scan_sequencer_if.slave    bus
);

    localparam int unsigned CNT_W = (DWELL_W > 4) ? DWELL_W : 4;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             r_state,     w_state;
    logic [CNT_W-1:0]   r_cnt,       w_cnt;
    logic [2:0]         r_addr,      w_addr;
    logic               r_g_n,       w_g_n;
    logic               r_busy,      w_busy;
    logic               r_done,      w_done;
    logic               r_wrap,      w_wrap;
    logic               r_stop_pend, w_stop_pend;
    logic               r_cont,      w_cont;
    logic [DWELL_W-1:0] r_dwell_m1,  w_dwell_m1;
    logic [2:0]         r_first,     w_first;
    logic [2:0]         r_last,      w_last;
    logic [DWELL_W-1:0] w_dwell_in;
    logic               w_hold_pend;

    assign w_dwell_in = DWELL_W'(bus.dwell);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_g_n       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_cont      <= 1'b0;
            r_dwell_m1  <= '0;
            r_first     <= '0;
            r_last      <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_addr      <= w_addr;
            r_g_n       <= w_g_n;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_wrap      <= w_wrap;
            r_stop_pend <= w_stop_pend;
            r_cont      <= w_cont;
            r_dwell_m1  <= w_dwell_m1;
            r_first     <= w_first;
            r_last      <= w_last;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_addr      = r_addr;
        w_g_n       = r_g_n;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_wrap      = 1'b0;
        w_stop_pend = r_stop_pend;
        w_cont      = r_cont;
        w_dwell_m1  = r_dwell_m1;
        w_first     = r_first;
        w_last      = r_last;
        w_hold_pend = r_stop_pend | bus.stop;

        case (r_state)
            S_IDLE: begin
                w_g_n  = 1'b1;
                w_busy = 1'b0;
                if (bus.start && !bus.stop) begin
                    w_cont      = bus.cont;
                    w_dwell_m1  = (w_dwell_in == '0) ? '0 : w_dwell_in - DWELL_W'(1);
                    w_first     = bus.first;
                    w_last      = bus.last;
                    w_addr      = bus.first;
                    w_cnt       = '0;
                    w_busy      = 1'b1;
                    w_stop_pend = 1'b0;
                    w_state     = S_SETUP;
                end
            end

            S_SETUP: begin
                if (bus.stop) begin
                    w_stop_pend = 1'b1;
                    w_g_n       = 1'b1;
                    w_cnt       = '0;
                    w_state     = S_HOLD;
                end else if (r_cnt == SETUP_LAST) begin
                    w_g_n   = 1'b0;
                    w_cnt   = '0;
                    w_state = S_STROBE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            S_STROBE: begin
                if (bus.stop) begin
                    w_stop_pend = 1'b1;
                    w_g_n       = 1'b1;
                    w_cnt       = '0;
                    w_state     = S_HOLD;
                end else if (r_cnt == CNT_W'(r_dwell_m1)) begin
                    w_g_n   = 1'b1;
                    w_cnt   = '0;
                    w_state = S_HOLD;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            S_HOLD: begin
                w_g_n       = 1'b1;
                w_stop_pend = w_hold_pend;
                if (r_cnt == HOLD_LAST) begin
                    w_cnt = '0;
                    // A pending stop outranks both the wrap reload and the window end
                    if (w_hold_pend || (r_addr == r_last && !r_cont)) begin
                        w_busy      = 1'b0;
                        w_done      = 1'b1;
                        w_stop_pend = 1'b0;
                        w_state     = S_IDLE;
                    end else if (r_addr == r_last) begin
                        w_addr  = r_first;
                        w_wrap  = 1'b1;
                        w_state = S_SETUP;
                    end else begin
                        w_addr  = r_addr + 3'd1;
                        w_state = S_SETUP;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.A    = r_addr[0];
    assign bus.B    = r_addr[1];
    assign bus.C    = r_addr[2];
    assign bus.G_n  = r_g_n;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_ttl_scan_sequencer.sv
// Self-checking bench for ttl_scan_sequencer: vector table, randomized scans against a
// cycle-position reference model, and hand-written reset / start+stop / 74155 sequences.
module tb_ttl_scan_sequencer;

    localparam int unsigned TB_DW    = 8;
    localparam int          TB_SETUP = 1;
    localparam int          TB_HOLD  = 1;

    typedef struct {
        bit cont;
        int dwell;
        int first;
        int last;
        int stop_p;
        int exp_end;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ttl_scan_sequencer_if #(.DWELL_W(TB_DW)) bus ();

    ttl_scan_sequencer #(
        .DWELL_W  (TB_DW),
        .SETUP_CYC(TB_SETUP),
        .HOLD_CYC (TB_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s p=%0d actual=%0h expected=%0h", name, p, act, exp);
        end
    endtask

    // Cycle index at which done is expected (cycle 0 = first cycle with busy high)
    function automatic int p_end_of(vec_t v);
        int d, per, n, nat;
        d   = (v.dwell == 0) ? 1 : v.dwell;
        per = TB_SETUP + d + TB_HOLD;
        n   = ((v.last - v.first) & 7) + 1;
        nat = v.cont ? (1 << 30) : n * per;
        if (v.stop_p >= 0 && v.stop_p < nat) begin
            if ((v.stop_p % per) < TB_SETUP + d) return v.stop_p + 1 + TB_HOLD;
            return (v.stop_p / per + 1) * per;
        end
        return nat;
    endfunction

    // Expected {addr[2:0], G_n, busy, done, wrap} at cycle p of a scan
    function automatic logic [6:0] model(vec_t v, int p);
        int d, per, n, pe, q;
        logic [2:0] a;
        logic g;
        d   = (v.dwell == 0) ? 1 : v.dwell;
        per = TB_SETUP + d + TB_HOLD;
        n   = ((v.last - v.first) & 7) + 1;
        pe  = p_end_of(v);
        q   = (p < pe) ? p : pe - 1;
        a   = 3'(v.first + (q / per) % n);
        if (p >= pe) return {a, 1'b1, 1'b0, 1'(p == pe), 1'b0};
        g = !((p % per) >= TB_SETUP && (p % per) < TB_SETUP + d);
        if (v.stop_p >= 0 && p > v.stop_p && (v.stop_p % per) < TB_SETUP + d) g = 1'b1;
        return {a, g, 1'b1, 1'b0, 1'(v.cont && p > 0 && (p % (n * per)) == 0)};
    endfunction

    // 74155 in 3-to-8 mode: section 1 enabled by C=1, section 2 by C=0; both strobed by G_n
    function automatic logic [7:0] dec74155(logic c, logic b, logic a, logic g_n);
        logic [7:0] r;
        int idx;
        r   = 8'hFF;
        idx = int'({b, a});
        if (!g_n && c)  r[4 + idx] = 1'b0;
        if (!g_n && !c) r[idx]     = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.C, bus.B, bus.A, bus.G_n, bus.busy, bus.done, bus.wrap};
    endfunction

    task automatic start_scan(input vec_t v);
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.cont  = v.cont;
        bus.dwell = TB_DW'(v.dwell);
        bus.first = 3'(v.first);
        bus.last  = 3'(v.last);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_scan(input vec_t v, input string name);
        int pe, meas;
        logic [6:0] act;
        logic [2:0] pa;
        logic pg;
        pe   = p_end_of(v);
        meas = -1;
        pa   = {bus.C, bus.B, bus.A};
        pg   = bus.G_n;
        start_scan(v);
        for (int p = 0; p < pe + 3; p++) begin
            act = outs();
            check(name, p, 32'(act), 32'(model(v, p)));
            if (bus.done === 1'b1 && meas < 0) meas = p;
            if (act[6:4] !== pa) begin
                checks++;
                if (!(pg === 1'b1 && bus.G_n === 1'b1)) begin
                    errors++;
                    $display("FAIL %s_glitch p=%0d addr %0d->%0d G_n prev=%b now=%b", name, p, pa, act[6:4], pg, bus.G_n);
                end
            end
            pa = act[6:4];
            pg = bus.G_n;
            bus.start = (p < pe) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.stop  = (p == v.stop_p);
            bus.cont  = 1'($urandom_range(0, 1));
            bus.dwell = TB_DW'($urandom);
            bus.first = 3'($urandom_range(0, 7));
            bus.last  = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check({name, "_len"}, pe, meas, (v.exp_end < 0) ? pe : v.exp_end);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        int n, per, d, illegal;
        int falls[8];
        logic [7:0] r, pr;

        checks = 0;
        errors = 0;
        tbl[0] = '{0, 2, 0, 3, -1, 16};
        tbl[1] = '{0, 1, 6, 1, -1, 12};
        tbl[2] = '{0, 0, 5, 5, -1, 3};
        tbl[3] = '{0, 1, 5, 5, -1, 3};
        tbl[4] = '{1, 3, 2, 2, 17, 19};
        tbl[5] = '{0, 4, 7, 0, -1, 12};
        tbl[6] = '{1, 1, 3, 4, 2, 3};
        tbl[7] = '{1, 2, 0, 7, 0, 2};
        tbl[8] = '{0, 255, 4, 4, -1, 257};

        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
        bus.dwell = '0;   bus.first = '0;  bus.last = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 32'(outs()), 32'(7'b000_1_000));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_scan(tbl[i], $sformatf("tbl%0d", i));

        // start and stop together in IDLE: no scan
        bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        check("startstop", 0, 32'(outs() & 7'b000_1111), 32'(7'b000_1000));
        @(posedge clk); #1;
        check("startstop", 1, 32'(outs() & 7'b000_1111), 32'(7'b000_1000));

        // reset mid-STROBE abandons the scan without done
        v = '{0, 3, 5, 7, -1, -1};
        start_scan(v);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_gn", 2, 32'(bus.G_n), 32'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid", 0, 32'(outs()), 32'(7'b000_1_000));
        @(posedge clk); #1;
        check("rst_mid", 1, 32'(outs()), 32'(7'b000_1_000));
        run_scan('{0, 2, 1, 2, -1, 8}, "after_rst");

        for (int k = 0; k < 40; k++) begin
            v.cont  = 1'($urandom_range(0, 1));
            v.dwell = $urandom_range(0, 6);
            v.first = $urandom_range(0, 7);
            v.last  = $urandom_range(0, 7);
            d   = (v.dwell == 0) ? 1 : v.dwell;
            per = TB_SETUP + d + TB_HOLD;
            n   = ((v.last - v.first) & 7) + 1;
            if (v.cont) v.stop_p = $urandom_range(0, 2 * n * per);
            else        v.stop_p = ($urandom_range(0, 1) != 0) ? -1 : $urandom_range(0, n * per - 1);
            v.exp_end = -1;
            run_scan(v, $sformatf("rnd%0d", k));
        end

        // 74155 integration: every output strobes exactly once, only under G_n=0
        v = '{0, 2, 0, 7, -1, -1};
        for (int i = 0; i < 8; i++) falls[i] = 0;
        illegal = 0;
        pr = 8'hFF;
        start_scan(v);
        for (int p = 0; p < 8 * 4 + 3; p++) begin
            r = dec74155(bus.C, bus.B, bus.A, bus.G_n);
            for (int i = 0; i < 8; i++) begin
                if (r[i] == 1'b0 && bus.G_n !== 1'b0) illegal++;
                if (pr[i] == 1'b1 && r[i] == 1'b0) falls[i]++;
            end
            if ($countones(~r) > 1) illegal++;
            pr = r;
            @(posedge clk); #1;
        end
        check("dec_illegal", 0, 32'(illegal), 32'(0));
        for (int i = 0; i < 8; i++) check($sformatf("dec_fall%0d", i), i, 32'(falls[i]), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
